// File: rtl/jkx_pkg.sv
// jkx_pkg: state encoding and JK excitation codes shared by jk_excite_ctrl and its cell encoder.
package jkx_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDrive = 2'd1,
        StCheck = 2'd2,
        StDone  = 2'd3
    } jkx_state_e;

    // Per-cell excitation, {J,K}.
    localparam logic [1:0] JK_HOLD = 2'b11;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_TGL  = 2'b00;

    // Toggle is never emitted: its outcome depends on the cell's prior value.
    function automatic logic [1:0] jkx_excite(input logic q, input logic tgt, input logic en);
        if (!en || (q == tgt)) begin
            return JK_HOLD;
        end
        return tgt ? JK_SET : JK_CLR;
    endfunction

endpackage

// File: rtl/jkx_cell_enc.sv
// jkx_cell_enc: combinational excitation encoder for one JK cell.
module jkx_cell_enc
    import jkx_pkg::*;
(
    input  logic       q_i,
    input  logic       tgt_i,
    input  logic       en_i,
    output logic [1:0] jk_o
);

    // Hold unless enabled and the cell disagrees with its target bit.
    always_comb begin
        jk_o = jkx_excite(q_i, tgt_i, en_i);
        assert (jk_o != JK_TGL);
    end

endmodule

// File: rtl/jk_excite_ctrl.sv
// jk_excite_ctrl: drives a bank of WIDTH JK cells toward an accepted target word.
// Optional feature macro: JKX_VERIFY_EN adds the CHECK state, retries and the sticky err flag.
// Without it DRIVE goes straight to DONE and err is tied low.
module jk_excite_ctrl
    import jkx_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic             tgt_step,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned IdxW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(WIDTH - 1);

    if (WIDTH == 0 || MAX_RETRY > 7) begin : g_bad_params
        $error("jk_excite_ctrl: WIDTH must be >= 1 and MAX_RETRY 0..7");
    end

    jkx_state_e       state_q, state_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic             step_q, step_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] j_q, j_d;
    logic [WIDTH-1:0] k_q, k_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] en_mask;

`ifdef JKX_VERIFY_EN
    localparam logic [2:0] MaxRetry = 3'(MAX_RETRY);
    logic [2:0] retry_q, retry_d;
    logic       err_q, err_d;
`endif

    // Next-state decode plus the excitation enable for the cycle being entered.
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        step_d  = step_q;
        idx_d   = idx_q;
`ifdef JKX_VERIFY_EN
        retry_d = retry_q;
        err_d   = err_q;
`endif
        case (state_q)
            StIdle: begin
                if (tgt_valid) begin
                    tgt_d   = tgt_data;
                    step_d  = tgt_step;
                    idx_d   = '0;
                    state_d = StDrive;
`ifdef JKX_VERIFY_EN
                    retry_d = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            StDrive: begin
                if (!step_q || (idx_q == LastIdx)) begin
                    idx_d = '0;
`ifdef JKX_VERIFY_EN
                    state_d = StCheck;
`else
                    state_d = StDone;
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
`ifdef JKX_VERIFY_EN
            StCheck: begin
                if (q_fb == tgt_q) begin
                    state_d = StDone;
                end else if (retry_q < MaxRetry) begin
                    retry_d = retry_q + 3'd1;
                    idx_d   = '0;
                    state_d = StDrive;
                end else begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end
            end
`endif
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // j/k are registered, so the excitation for the next DRIVE cycle is built
        // from the q_fb seen now; each cell is independent, so that is still current.
        en_mask = '0;
        if (state_d == StDrive) begin
            en_mask = step_d ? (WIDTH'(1) << idx_d) : '1;
        end

        ready_d = (state_d == StIdle);
        busy_d  = (state_d != StIdle);
        done_d  = (state_d == StDone);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic [1:0] jk;
        jkx_cell_enc u_enc (
            .q_i  (q_fb[i]),
            .tgt_i(tgt_d[i]),
            .en_i (en_mask[i]),
            .jk_o (jk)
        );
        assign j_d[i] = jk[1];
        assign k_d[i] = jk[0];
    end

    // State and registered outputs; reset puts the bank on hold immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            tgt_q   <= '0;
            step_q  <= 1'b0;
            idx_q   <= '0;
            j_q     <= '1;
            k_q     <= '1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef JKX_VERIFY_EN
            retry_q <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            step_q  <= step_d;
            idx_q   <= idx_d;
            j_q     <= j_d;
            k_q     <= k_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef JKX_VERIFY_EN
            retry_q <= retry_d;
            err_q   <= err_d;
`endif
        end
    end

    assign j         = j_q;
    assign k         = k_q;
    assign tgt_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
`ifdef JKX_VERIFY_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_jk_excite_ctrl.sv
// tb_jk_excite_ctrl: self-checking bench for jk_excite_ctrl with a JK bank model
// (optionally with stuck bits) and a transaction-level expected-output schedule.
module tb_jk_excite_ctrl;

    localparam int unsigned W  = 4;
    localparam int unsigned MR = 2;

`ifdef JKX_VERIFY_EN
    localparam int   BULK_LAT     = 3;
    localparam int   STEP_LAT     = 6;
    localparam int   STUCK_PASSES = 3;
    localparam logic STUCK_ERR    = 1'b1;
`else
    localparam int   BULK_LAT     = 2;
    localparam int   STEP_LAT     = 5;
    localparam int   STUCK_PASSES = 1;
    localparam logic STUCK_ERR    = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         tgt_valid;
    logic [W-1:0] tgt_data;
    logic         tgt_step;
    logic         tgt_ready;
    logic [W-1:0] q_fb;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic         busy;
    logic         done;
    logic         err;

    jk_excite_ctrl #(.WIDTH(W), .MAX_RETRY(MR)) dut (
        .clk      (clk),
        .rst      (rst),
        .tgt_valid(tgt_valid),
        .tgt_data (tgt_data),
        .tgt_step (tgt_step),
        .tgt_ready(tgt_ready),
        .q_fb     (q_fb),
        .j        (j),
        .k        (k),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // ---------------- JK bank environment ----------------
    logic [W-1:0] bank_q;
    logic [W-1:0] load_val;
    logic [W-1:0] stuck_mask;
    logic [W-1:0] stuck_val;
    logic         load_en;

    function automatic logic [W-1:0] jk_apply(input logic [W-1:0] q, input logic [W-1:0] jj,
                                              input logic [W-1:0] kk);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            case ({jj[i], kk[i]})
                2'b11:   r[i] = q[i];
                2'b10:   r[i] = 1'b1;
                2'b01:   r[i] = 1'b0;
                default: r[i] = ~q[i];
            endcase
        end
        return r;
    endfunction

    function automatic logic [W-1:0] force_stuck(input logic [W-1:0] q);
        return (q & ~stuck_mask) | (stuck_val & stuck_mask);
    endfunction

    always @(posedge clk) begin
        bank_q <= force_stuck(load_en ? load_val : jk_apply(bank_q, j, k));
    end
    assign q_fb = bank_q;

    // ---------------- expected-output model ----------------
    typedef struct packed {
        logic [W-1:0] j;
        logic [W-1:0] k;
        logic         busy;
        logic         ready;
        logic         done;
        logic         err;
    } exp_t;

    exp_t sched[$];
    exp_t cur;

    function automatic exp_t mk(input logic [W-1:0] jj, input logic [W-1:0] kk, input logic b,
                                input logic r, input logic d, input logic e);
        return {jj, kk, b, r, d, e};
    endfunction

    // A mismatching bit is driven toward its target; everything else holds.
    function automatic exp_t drive_exp(input logic [W-1:0] mism, input logic [W-1:0] tgt);
        return mk(~(mism & ~tgt), ~(mism & tgt), 1'b1, 1'b0, 1'b0, 1'b0);
    endfunction

    // Whole transaction worked out up front: passes of DRIVE (then CHECK), then DONE.
    task automatic build(input logic [W-1:0] q0, input logic [W-1:0] tgt, input logic step);
        logic [W-1:0] mq;
        logic [W-1:0] mism;
        logic         e;
        mq = q0;
        e  = 1'b0;
        for (int p = 0; p <= int'(MR); p++) begin
            if (!step) begin
                mism = mq ^ tgt;
                sched.push_back(drive_exp(mism, tgt));
                mq = force_stuck((mq & ~mism) | (tgt & mism));
            end else begin
                for (int i = 0; i < int'(W); i++) begin
                    mism = (mq ^ tgt) & (W'(1) << i);
                    sched.push_back(drive_exp(mism, tgt));
                    mq = force_stuck((mq & ~mism) | (tgt & mism));
                end
            end
`ifdef JKX_VERIFY_EN
            sched.push_back(mk('1, '1, 1'b1, 1'b0, 1'b0, 1'b0));
            if (mq == tgt) break;
            if (p == int'(MR)) e = 1'b1;
`else
            break;
`endif
        end
        sched.push_back(mk('1, '1, 1'b1, 1'b0, 1'b1, e));
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sched.delete();
            cur <= mk('1, '1, 1'b0, 1'b1, 1'b0, 1'b0);
        end else if (sched.size() != 0) begin
            cur <= sched.pop_front();
        end else if (cur.ready && tgt_valid) begin
            build(q_fb, tgt_data, tgt_step);
            cur <= sched.pop_front();
        end else begin
            cur <= mk('1, '1, 1'b0, 1'b1, 1'b0, cur.err);
        end
    end

    // ---------------- checking and stimulus ----------------
    int   total;
    int   bad;
    exp_t s;
    exp_t hist [0:64];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    // One cycle: compare all outputs to the model mid-cycle, then advance past the edge.
    task automatic tick();
        exp_t got;
        @(negedge clk);
        got = {j, k, busy, tgt_ready, done, err};
        total++;
        if (got !== cur) begin
            bad++;
            $display("FAIL cycle @%0t got j=%h k=%h busy=%b rdy=%b done=%b err=%b want j=%h k=%h busy=%b rdy=%b done=%b err=%b",
                     $time, got.j, got.k, got.busy, got.ready, got.done, got.err,
                     cur.j, cur.k, cur.busy, cur.ready, cur.done, cur.err);
        end
        s = got;
        @(posedge clk);
        #2;
    endtask

    task automatic load_bank(input logic [W-1:0] v);
        load_en  = 1'b1;
        load_val = v;
        tick();
        load_en  = 1'b0;
    endtask

    // Offer one target while idle, wait for done; lat counts cycles from the accept edge.
    task automatic run_txn(input logic [W-1:0] t, input logic st, output int lat, output int nact);
        logic got_done;
        tgt_valid = 1'b1;
        tgt_data  = t;
        tgt_step  = st;
        tick();
        tgt_valid = 1'b0;
        lat = 0;
        nact = 0;
        got_done = 1'b0;
        while (!got_done && lat < 64) begin
            tick();
            lat++;
            hist[lat] = s;
            if (s.j != '1 || s.k != '1) nact++;
            if (s.done) got_done = 1'b1;
        end
        if (!got_done) chk("done_timeout", 32'(got_done), 32'd1);
    endtask

    initial begin
        int lat;
        int nact;
        total      = 0;
        bad        = 0;
        tgt_valid  = 1'b0;
        tgt_data   = '0;
        tgt_step   = 1'b0;
        load_en    = 1'b1;
        load_val   = '0;
        stuck_mask = '0;
        stuck_val  = '0;
        rst        = 1'b1;
        #1 rst     = 1'b0;

        // Reset state
        tick();
        load_en = 1'b0;
        tick();
        chk("rst_j", 32'(s.j), 32'hF);
        chk("rst_k", 32'(s.k), 32'hF);
        chk("rst_ready", 32'(s.ready), 32'd1);
        chk("rst_busy", 32'(s.busy), 32'd0);
        rst = 1'b1;
        tick();

        // Bulk: q=0101 -> 0011
        load_bank(4'b0101);
        run_txn(4'b0011, 1'b0, lat, nact);
        chk("bulk_j", 32'(hist[1].j), 32'b1011);
        chk("bulk_k", 32'(hist[1].k), 32'b1101);
        chk("bulk_lat", 32'(lat), 32'(BULK_LAT));
        chk("bulk_err", 32'(s.err), 32'd0);
        tick();
        chk("bulk_bank", 32'(bank_q), 32'b0011);

        // Step: q=0000 -> 1001
        load_bank(4'b0000);
        run_txn(4'b1001, 1'b1, lat, nact);
        chk("step_c1_j", 32'(hist[1].j), 32'hF);
        chk("step_c1_k", 32'(hist[1].k), 32'b1110);
        chk("step_c2_k", 32'({hist[2].j, hist[2].k, hist[3].j, hist[3].k}), 32'hFFFF);
        chk("step_c4_k", 32'(hist[4].k), 32'b0111);
        chk("step_lat", 32'(lat), 32'(STEP_LAT));
        tick();

        // Stuck bit2 at 0, target 0100
        stuck_mask = 4'b0100;
        stuck_val  = 4'b0000;
        load_bank(4'b0000);
        run_txn(4'b0100, 1'b0, lat, nact);
        chk("stuck_passes", 32'(nact), 32'(STUCK_PASSES));
        chk("stuck_err", 32'(s.err), 32'(STUCK_ERR));
        tick();
        chk("stuck_err_idle", 32'(s.err), 32'(STUCK_ERR));
        stuck_mask = '0;
        load_bank(4'b0000);
        run_txn(4'b0000, 1'b0, lat, nact);
        chk("err_clr_accept", 32'(hist[1].err), 32'd0);
        chk("equal_hold", 32'({hist[1].j, hist[1].k}), 32'hFF);
        chk("equal_lat", 32'(lat), 32'(BULK_LAT));
        tick();

        // Handshake: valid held high with data changing every cycle
        tgt_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tgt_data = W'($urandom);
            tgt_step = 1'($urandom_range(0, 1));
            tick();
        end
        tgt_valid = 1'b0;
        for (int c = 0; c < 20 && !cur.ready; c++) tick();
        tick();

        // Reset mid-DRIVE (step mode)
        load_bank(4'b0000);
        tgt_valid = 1'b1;
        tgt_data  = 4'hF;
        tgt_step  = 1'b1;
        tick();
        tgt_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_j", 32'(j), 32'hF);
        chk("mid_rst_k", 32'(k), 32'hF);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(tgt_ready), 32'd1);
        chk("mid_rst_done", 32'(done), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        run_txn(4'b1010, 1'b0, lat, nact);
        chk("post_rst_lat", 32'(lat), 32'(BULK_LAT));
        tick();
        chk("post_rst_bank", 32'(bank_q), 32'b1010);

        // Randomized traffic, bank loads and stuck bits
        for (int c = 0; c < 2000; c++) begin
            tgt_valid = ($urandom_range(0, 2) != 0);
            tgt_data  = W'($urandom);
            tgt_step  = 1'($urandom_range(0, 1));
            load_en   = 1'b0;
            if (cur.ready && !tgt_valid && $urandom_range(0, 3) == 0) begin
                stuck_mask = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
                stuck_val  = W'($urandom);
                load_val   = W'($urandom);
                load_en    = 1'b1;
            end
            tick();
        end
        tgt_valid = 1'b0;
        load_en   = 1'b0;
        for (int c = 0; c < 40 && !cur.ready; c++) tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
